// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating multiplexer.
// Optional parity output is enabled by defining RR_MUX_PARITY_EN.
package rr_mux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int MAX_N = 16;

  // Select/index width; a single source still needs one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_mux_arb_pick.sv
// Combinational rotating-priority encoder: first requester at or after ptr,
// wrapping through N-1 back to 0.
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] g,
  output logic          found,
  output logic [N-1:0]  onehot
);

  logic [SW-1:0]    idx;
  logic [MAX_N-1:0] oh_ext;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = SW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found       = 1'b1;
        onehot[idx] = 1'b1;
      end
    end
    oh_ext         = '0;
    oh_ext[N-1:0]  = onehot;
    g              = SW'(onehot_to_idx(oh_ext));
  end

endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin arbitrating mux with a registered output word and valid/ready
// handshake. Define RR_MUX_PARITY_EN to add the registered Y_par output.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sel_w(N)
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [N-1:0]    Req,
  input  logic [N*W-1:0]  D,
  output logic [N-1:0]    Ack,
  output logic [SW-1:0]   Sel,
  output logic [W-1:0]    Y,
  output logic            Y_valid,
  input  logic            Y_ready
`ifdef RR_MUX_PARITY_EN
  ,
  output logic            Y_par
`endif
);

  state_t        state_p1, state_nxt;
  logic [SW-1:0] ptr_p1;
  logic [SW-1:0] g;
  logic          found;
  logic [N-1:0]  onehot;
  logic          ld;
  logic [SW-1:0] ptr_nxt;
  logic [W-1:0]  d_sel;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req    (Req),
    .ptr    (ptr_p1),
    .g      (g),
    .found  (found),
    .onehot (onehot)
  );

  assign Y_valid = (state_p1 == FULL);
  // A load may proceed whenever the output slot is free or being drained now.
  assign ld      = (!Y_valid || Y_ready) && found;
  assign Ack     = (ld && Rst_n) ? onehot : '0;
  assign d_sel   = D[int'(g)*W +: W];
  assign ptr_nxt = (int'(g) == N-1) ? '0 : g + 1'b1;

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY:   if (ld) state_nxt = FULL;
      FULL:    if (ld) state_nxt = FULL;
               else if (Y_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_p1 <= EMPTY;
    else        state_p1 <= state_nxt;
  end

  // Output register stage: word, select and pointer move only on a grant.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Y      <= '0;
      Sel    <= '0;
      ptr_p1 <= '0;
    end else if (ld) begin
      Y      <= d_sel;
      Sel    <= g;
      ptr_p1 <= ptr_nxt;
    end
  end

`ifdef RR_MUX_PARITY_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)  Y_par <= 1'b0;
    else if (ld) Y_par <= ^d_sel;
  end
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb (N=4, W=8): vector table plus hand-written
// rotation, back-pressure and reset sequences.
module tb_rr_mux_arb;

  logic        Clk;
  logic        Rst_n;
  logic [3:0]  Req;
  logic [31:0] D;
  logic [3:0]  Ack;
  logic [1:0]  Sel;
  logic [7:0]  Y;
  logic        Y_valid;
  logic        Y_ready;
`ifdef RR_MUX_PARITY_EN
  logic        Y_par;
`endif

  int checks = 0;
  int errors = 0;

  rr_mux_arb #(.N(4), .W(8)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Req     (Req),
    .D       (D),
    .Ack     (Ack),
    .Sel     (Sel),
    .Y       (Y),
    .Y_valid (Y_valid),
`ifdef RR_MUX_PARITY_EN
    .Y_par   (Y_par),
`endif
    .Y_ready (Y_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] d;
    logic        ready;
    logic [3:0]  ack;
    logic [7:0]  y;
    logic [1:0]  sel;
    logic        valid;
  } vec_t;

  vec_t tbl[14];

  localparam logic [31:0] D0 = 32'hD3A55A3C;  // slices 3C,5A,A5,D3
  localparam logic [31:0] D1 = 32'h81422418;  // slices 18,24,42,81

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    Req   = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'b0100, D0, 1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1};
    tbl[1]  = '{4'b1111, D0, 1'b1, 4'b1000, 8'hD3, 2'd3, 1'b1};
    tbl[2]  = '{4'b1111, D0, 1'b1, 4'b0001, 8'h3C, 2'd0, 1'b1};
    tbl[3]  = '{4'b1111, D0, 1'b0, 4'b0000, 8'h3C, 2'd0, 1'b1};
    tbl[4]  = '{4'b0000, D1, 1'b0, 4'b0000, 8'h3C, 2'd0, 1'b1};
    tbl[5]  = '{4'b0010, D0, 1'b1, 4'b0010, 8'h5A, 2'd1, 1'b1};
    tbl[6]  = '{4'b0000, D0, 1'b1, 4'b0000, 8'h5A, 2'd1, 1'b0};
    tbl[7]  = '{4'b0000, D0, 1'b0, 4'b0000, 8'h5A, 2'd1, 1'b0};
    tbl[8]  = '{4'b0011, D0, 1'b0, 4'b0001, 8'h3C, 2'd0, 1'b1};
    tbl[9]  = '{4'b0011, D0, 1'b1, 4'b0010, 8'h5A, 2'd1, 1'b1};
    tbl[10] = '{4'b0011, D0, 1'b1, 4'b0001, 8'h3C, 2'd0, 1'b1};
    tbl[11] = '{4'b1001, D0, 1'b1, 4'b1000, 8'hD3, 2'd3, 1'b1};
    tbl[12] = '{4'b1000, D1, 1'b1, 4'b1000, 8'h81, 2'd3, 1'b1};
    tbl[13] = '{4'b0000, D1, 1'b1, 4'b0000, 8'h81, 2'd3, 1'b0};

    Rst_n   = 1'b0;
    Req     = 4'hF;
    D       = D0;
    Y_ready = 1'b1;
    #2;
    check("reset_y_valid", 32'(Y_valid), 32'd0);
    check("reset_y", 32'(Y), 32'd0);
    check("reset_sel", 32'(Sel), 32'd0);
    check("reset_ack", 32'(Ack), 32'd0);
`ifdef RR_MUX_PARITY_EN
    check("reset_y_par", 32'(Y_par), 32'd0);
`endif
    Req = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      Req     = tbl[i].req;
      D       = tbl[i].d;
      Y_ready = tbl[i].ready;
      #1;
      check($sformatf("vec%0d_ack", i), 32'(Ack), 32'(tbl[i].ack));
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d_y", i), 32'(Y), 32'(tbl[i].y));
      check($sformatf("vec%0d_sel", i), 32'(Sel), 32'(tbl[i].sel));
      check($sformatf("vec%0d_valid", i), 32'(Y_valid), 32'(tbl[i].valid));
`ifdef RR_MUX_PARITY_EN
      check($sformatf("vec%0d_par", i), 32'(Y_par), 32'(^tbl[i].y));
`endif
    end

    // Rotation from reset with every source requesting.
    pulse_reset();
    Req     = 4'hF;
    D       = D0;
    Y_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rot%0d_ack", i), 32'(Ack), 32'(4'b0001 << (i % 4)));
      @(posedge Clk);
      #1;
      check($sformatf("rot%0d_sel", i), 32'(Sel), 32'(i % 4));
      check($sformatf("rot%0d_valid", i), 32'(Y_valid), 32'd1);
    end

    // Back-pressure while FULL with Sel=1.
    Y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_ack", i), 32'(Ack), 32'd0);
      @(posedge Clk);
      #1;
      check($sformatf("bp%0d_sel", i), 32'(Sel), 32'd1);
      check($sformatf("bp%0d_y", i), 32'(Y), 32'h5A);
      check($sformatf("bp%0d_valid", i), 32'(Y_valid), 32'd1);
    end
    Y_ready = 1'b1;
    #1;
    check("bp_release_ack", 32'(Ack), 32'b0100);
    @(posedge Clk);
    #1;
    check("bp_release_sel", 32'(Sel), 32'd2);
    check("bp_release_y", 32'(Y), 32'hA5);

    // Asynchronous reset while FULL with Sel=2.
    #2;
    Rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(Y_valid), 32'd0);
    check("midrst_y", 32'(Y), 32'd0);
    check("midrst_sel", 32'(Sel), 32'd0);
    check("midrst_ack", 32'(Ack), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("postrst_ack", 32'(Ack), 32'b0001);
    @(posedge Clk);
    #1;
    check("postrst_sel", 32'(Sel), 32'd0);
    check("postrst_y", 32'(Y), 32'h3C);
    check("postrst_valid", 32'(Y_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
